// File: rtl/oclib_csr_arbiter.sv
// Round-robin arbiter sharing one downstream CSR port among several CSR masters.
// The winning request is registered onto the shared port and its response routed back, with a timeout bound.
package oclib_pkg;
    typedef struct packed {
        logic [31:0] address;
        logic [31:0] wdata;
        logic        read;
        logic        write;
    } csr_32_s;

    typedef struct packed {
        logic [31:0] rdata;
        logic        ready;
        logic        error;
    } csr_32_fb_s;
endpackage

module oclib_csr_arbiter #(
    parameter type CsrType       = oclib_pkg::csr_32_s,
    parameter type CsrFbType     = oclib_pkg::csr_32_fb_s,
    parameter int  Requesters    = 2,
    parameter int  TimeoutCycles = 1024
) (
    input  logic                          clock,
    input  logic                          reset,
    input  CsrType                        csrIn    [Requesters],
    output CsrFbType                      csrInFb  [Requesters],
    output CsrType                        csrOut,
    input  CsrFbType                      csrOutFb,
    output logic [$clog2(Requesters)-1:0] grantIndex,
    output logic                          busy
);
    localparam int GW = $clog2(Requesters);
    localparam int CW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
    localparam logic [CW-1:0] TMO_LAST = CW'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);

    typedef enum logic [1:0] {IDLE, ACTIVE, FINISH} state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   ptr_q, ptr_d, grant_q, grant_d, win;
    logic [CW-1:0]   cnt_q, cnt_d;
    CsrType          out_q, out_d;
    CsrFbType        fb_q [Requesters];
    CsrFbType        fb_d [Requesters];
    logic            found, resp, tmo, g_req, win_illegal;
    int              idx;

    assign resp        = csrOutFb.ready | csrOutFb.error;
    assign tmo         = (TimeoutCycles != 0) && (cnt_q == TMO_LAST);
    assign g_req       = csrIn[grant_q].read | csrIn[grant_q].write;
    assign win_illegal = csrIn[win].read & csrIn[win].write;

    // First pending requester at or after the pointer, wrapping.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int i = 0; i < Requesters; i++) begin
            idx = (int'(ptr_q) + i) % Requesters;
            if (!found && (csrIn[idx].read || csrIn[idx].write)) begin
                found = 1'b1;
                win   = GW'(idx);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (found) state_d = win_illegal ? FINISH : ACTIVE;
            ACTIVE:  if (resp || tmo) state_d = FINISH;
            FINISH:  if (!g_req) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        out_d   = out_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        for (int i = 0; i < Requesters; i++) begin
            fb_d[i]       = fb_q[i];
            fb_d[i].ready = 1'b0;
            fb_d[i].error = 1'b0;
        end
        case (state_q)
            IDLE: if (found) begin
                grant_d = win;
                if (win_illegal) begin
                    fb_d[win].error = 1'b1;
                end else begin
                    out_d = csrIn[win];
                    cnt_d = '0;
                end
            end
            ACTIVE: if (resp) begin
                out_d.read            = 1'b0;
                out_d.write           = 1'b0;
                fb_d[grant_q].ready   = csrOutFb.ready;
                fb_d[grant_q].error   = csrOutFb.error;
                fb_d[grant_q].rdata   = csrOutFb.rdata;
            end else if (tmo) begin
                out_d.read            = 1'b0;
                out_d.write           = 1'b0;
                fb_d[grant_q].error   = 1'b1;
                fb_d[grant_q].rdata   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            // Hold off re-arbitration until the winner has dropped its request.
            FINISH: if (!g_req) ptr_d = (grant_q == GW'(Requesters - 1)) ? '0 : grant_q + 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr_q   <= '0;
            grant_q <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            fb_q    <= '{default: '0};
        end else begin
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            fb_q    <= fb_d;
        end
    end

    assign csrOut     = out_q;
    assign csrInFb    = fb_q;
    assign grantIndex = grant_q;
    assign busy       = (state_q != IDLE);
endmodule

// File: tb/tb_oclib_csr_arbiter.sv
// Randomized bench for oclib_csr_arbiter: three masters, a random-latency target and
// occasional resets, checked cycle by cycle against a transaction-level reference.
module tb_oclib_csr_arbiter;
    import oclib_pkg::*;

    localparam int R  = 3;
    localparam int TO = 8;

    logic       clock = 1'b0;
    logic       reset;
    csr_32_s    csrIn   [R];
    csr_32_fb_s csrInFb [R];
    csr_32_s    csrOut;
    csr_32_fb_s csrOutFb;
    logic [1:0] grantIndex;
    logic       busy;

    oclib_csr_arbiter #(
        .Requesters    (R),
        .TimeoutCycles (TO)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .csrIn      (csrIn),
        .csrInFb    (csrInFb),
        .csrOut     (csrOut),
        .csrOutFb   (csrOutFb),
        .grantIndex (grantIndex),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: who owns the port, whether the access is still outstanding,
    // how many cycles it has been outstanding, and where the next scan starts.
    int         owner;
    bit         inflight;
    int         elapsed;
    int         rr;
    csr_32_s    e_out;
    csr_32_fb_s e_fb [R];
    int         e_grant;
    bit         e_busy;

    int t_wait;
    int ms   [R];
    int hold [R];

    function automatic void model_reset();
        owner    = -1;
        inflight = 1'b0;
        elapsed  = 0;
        rr       = 0;
        e_out    = '0;
        for (int m = 0; m < R; m++) e_fb[m] = '0;
        e_grant  = 0;
        e_busy   = 1'b0;
    endfunction

    // Advance the reference by one clock using the inputs about to be sampled.
    task automatic model_step();
        bit got;
        int c;
        for (int m = 0; m < R; m++) begin
            e_fb[m].ready = 1'b0;
            e_fb[m].error = 1'b0;
        end
        if (owner < 0) begin
            got = 1'b0;
            for (int k = 0; k < R; k++) begin
                c = (rr + k) % R;
                if (!got && (csrIn[c].read || csrIn[c].write)) begin
                    got     = 1'b1;
                    owner   = c;
                    e_grant = c;
                    if (csrIn[c].read && csrIn[c].write) begin
                        e_fb[c].error = 1'b1;
                        inflight      = 1'b0;
                    end else begin
                        e_out    = csrIn[c];
                        inflight = 1'b1;
                        elapsed  = 0;
                        t_wait   = $urandom_range(0, 10);
                    end
                end
            end
        end else if (inflight) begin
            elapsed++;
            if (csrOutFb.ready || csrOutFb.error) begin
                e_out.read  = 1'b0;
                e_out.write = 1'b0;
                e_fb[owner] = csrOutFb;
                inflight    = 1'b0;
            end else if (elapsed == TO) begin
                e_out.read        = 1'b0;
                e_out.write       = 1'b0;
                e_fb[owner].error = 1'b1;
                e_fb[owner].rdata = '0;
                inflight          = 1'b0;
            end
        end else if (!(csrIn[owner].read || csrIn[owner].write)) begin
            rr    = (owner + 1) % R;
            owner = -1;
        end
        e_busy = (owner >= 0);
    endtask

    task automatic drive();
        int k;
        if (owner >= 0 && inflight) begin
            csrOutFb.rdata = $urandom;
            if (t_wait == 0) begin
                csrOutFb.ready = ($urandom_range(0, 5) != 0);
                csrOutFb.error = !csrOutFb.ready;
            end else begin
                t_wait--;
                csrOutFb.ready = 1'b0;
                csrOutFb.error = 1'b0;
            end
        end else begin
            // Stray responses outside an access must never reach a master.
            csrOutFb.rdata = $urandom;
            csrOutFb.ready = ($urandom_range(0, 7) == 0);
            csrOutFb.error = 1'b0;
        end
        for (int m = 0; m < R; m++) begin
            if (ms[m] == 0) begin
                if ($urandom_range(0, 2) == 0) begin
                    k = $urandom_range(0, 9);
                    csrIn[m].address = $urandom;
                    csrIn[m].wdata   = $urandom;
                    csrIn[m].read    = (k < 5);
                    csrIn[m].write   = (k == 0) || (k >= 5);
                    ms[m] = 1;
                end
            end else if (ms[m] == 1) begin
                if (e_fb[m].ready || e_fb[m].error) begin
                    hold[m] = $urandom_range(0, 5);
                    ms[m]   = 2;
                end else if ($urandom_range(0, 39) == 0) begin
                    csrIn[m].read  = 1'b0;
                    csrIn[m].write = 1'b0;
                    ms[m] = 0;
                end
            end
            if (ms[m] == 2) begin
                if (hold[m] == 0) begin
                    csrIn[m].read  = 1'b0;
                    csrIn[m].write = 1'b0;
                    ms[m] = 0;
                end else begin
                    hold[m]--;
                end
            end
        end
    endtask

    task automatic check_all(input string ph);
        for (int m = 0; m < R; m++)
            chk($sformatf("%s fb%0d", ph, m), {62'd0, csrInFb[m]}, {62'd0, e_fb[m]});
        chk({ph, " csrOut"}, {30'd0, csrOut}, {30'd0, e_out});
        chk({ph, " grant"}, {94'd0, grantIndex}, 96'(e_grant));
        chk({ph, " busy"}, {95'd0, busy}, {95'd0, e_busy});
    endtask

    initial begin
        reset    = 1'b1;
        csrOutFb = '0;
        t_wait   = 0;
        for (int m = 0; m < R; m++) begin
            csrIn[m] = '0;
            ms[m]    = 0;
            hold[m]  = 0;
        end
        model_reset();
        repeat (2) @(negedge clock);
        check_all("reset");
        reset = 1'b0;
        for (int cyc = 0; cyc < 6000; cyc++) begin
            drive();
            model_step();
            if (cyc > 20 && $urandom_range(0, 299) == 0) begin
                reset = 1'b1;
                #1;
                model_reset();
                check_all("async_reset");
            end
            @(negedge clock);
            check_all("run");
            if (reset) reset = 1'b0;
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
